// File: rtl/ts_window_z_seq_pkg.sv
// Shared constants and FSM state encoding for the z-window sequencer.
package ts_window_z_seq_pkg;

    localparam int STUB_Z_PHY_BITS   = 12;
    localparam int WINDOW_Z_DAT_BITS = 8;
    localparam int STATE_BITS        = 3;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_ADD_LO = 3'd2,
        ST_ADD_HI = 3'd3,
        ST_CAPT   = 3'd4,
        ST_OUT    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/ts_window_z_seq_if.sv
// Stub-in / LUT / window-out bus of the z-window sequencer.
// master = surrounding logic (stub buffer, LUT, comparator); slave = sequencer.
interface ts_window_z_seq_if
    import ts_window_z_seq_pkg::*;
#(
    parameter int Z_BITS    = STUB_Z_PHY_BITS,
    parameter int OFS_BITS  = WINDOW_Z_DAT_BITS,
    parameter int ADDR_BITS = 6
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [Z_BITS-1:0]    in_z;
    logic [ADDR_BITS-1:0]        in_addr;

    logic                        lut_rd;
    logic [ADDR_BITS-1:0]        lut_addr;
    logic signed [OFS_BITS-1:0]  lut_lo;
    logic signed [OFS_BITS-1:0]  lut_hi;

    logic                        out_valid;
    logic                        out_ready;
    logic signed [Z_BITS-1:0]    out_lo;
    logic signed [Z_BITS-1:0]    out_hi;
    logic                        out_empty;

    modport master (
        output in_valid, in_z, in_addr, lut_lo, lut_hi, out_ready,
        input  in_ready, lut_rd, lut_addr, out_valid, out_lo, out_hi, out_empty
    );

    modport slave (
        input  in_valid, in_z, in_addr, lut_lo, lut_hi, out_ready,
        output in_ready, lut_rd, lut_addr, out_valid, out_lo, out_hi, out_empty
    );

endinterface

// File: rtl/ts_window_z_add.sv
// Registered signed adder: Z_BITS + OFS_BITS operands, Z_BITS+1 result so
// the sum can never wrap; one cycle of latency.
module ts_window_z_add #(
    parameter int Z_BITS   = 12,
    parameter int OFS_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [Z_BITS-1:0]   a,
    input  logic signed [OFS_BITS-1:0] b,
    output logic signed [Z_BITS:0]     sum
);

    logic [Z_BITS:0] a_ext;
    logic [Z_BITS:0] b_ext;

    assign a_ext = {a[Z_BITS-1], a};
    assign b_ext = {{(Z_BITS+1-OFS_BITS){b[OFS_BITS-1]}}, b};

    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= a_ext + b_ext;
        end
    end

endmodule

// File: rtl/ts_window_z_seq.sv
// Turns one accepted stub into a clamped (lo, hi) z window using a single
// shared adder: lookup, add lower offset, add upper offset, capture, present.
module ts_window_z_seq
    import ts_window_z_seq_pkg::*;
#(
    parameter int Z_BITS    = STUB_Z_PHY_BITS,
    parameter int OFS_BITS  = WINDOW_Z_DAT_BITS,
    parameter int ADDR_BITS = 6,
    parameter int Z_MIN     = -(2**(Z_BITS-1)),
    parameter int Z_MAX     = 2**(Z_BITS-1)-1
) (
    input logic               clk,
    input logic               rst,
    ts_window_z_seq_if.slave  bus
);

    localparam logic signed [Z_BITS:0] Z_MIN_W = (Z_BITS+1)'(Z_MIN);
    localparam logic signed [Z_BITS:0] Z_MAX_W = (Z_BITS+1)'(Z_MAX);

    seq_state_e                 state;
    seq_state_e                 state_nxt;
    logic signed [Z_BITS-1:0]   z_q;
    logic [ADDR_BITS-1:0]       addr_q;
    logic signed [OFS_BITS-1:0] ofs_hi_q;
    logic signed [OFS_BITS-1:0] add_b;
    logic signed [Z_BITS:0]     sum;
    logic signed [Z_BITS:0]     raw_lo_q;
    logic signed [Z_BITS-1:0]   lo_clamped;
    logic signed [Z_BITS-1:0]   hi_clamped;

    function automatic logic signed [Z_BITS-1:0] clamp(input logic signed [Z_BITS:0] v);
        if (v < Z_MIN_W) return Z_MIN_W[Z_BITS-1:0];
        if (v > Z_MAX_W) return Z_MAX_W[Z_BITS-1:0];
        return v[Z_BITS-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.lut_rd    = 1'b0;
        bus.out_valid = 1'b0;
        add_b         = ofs_hi_q;
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                bus.lut_rd = 1'b1;
                state_nxt  = ST_ADD_LO;
            end
            ST_ADD_LO: begin
                add_b     = bus.lut_lo;
                state_nxt = ST_ADD_HI;
            end
            ST_ADD_HI: state_nxt = ST_CAPT;
            ST_CAPT:   state_nxt = ST_OUT;
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    ts_window_z_add #(
        .Z_BITS   (Z_BITS),
        .OFS_BITS (OFS_BITS)
    ) u_add (
        .clk (clk),
        .rst (rst),
        .a   (z_q),
        .b   (add_b),
        .sum (sum)
    );

    // In CAPT the adder still holds the upper sum, so it is clamped straight from the adder.
    assign lo_clamped   = clamp(raw_lo_q);
    assign hi_clamped   = clamp(sum);
    assign bus.lut_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q           <= '0;
            addr_q        <= '0;
            ofs_hi_q      <= '0;
            raw_lo_q      <= '0;
            bus.out_lo    <= '0;
            bus.out_hi    <= '0;
            bus.out_empty <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.in_valid) begin
                z_q    <= bus.in_z;
                addr_q <= bus.in_addr;
            end
            // The lower offset goes straight into the adder; only the upper one needs holding.
            if (state == ST_ADD_LO) ofs_hi_q <= bus.lut_hi;
            if (state == ST_ADD_HI) raw_lo_q <= sum;
            if (state == ST_CAPT) begin
                bus.out_lo    <= lo_clamped;
                bus.out_hi    <= hi_clamped;
                bus.out_empty <= (lo_clamped > hi_clamped);
            end
        end
    end

endmodule

// File: tb/tb_ts_window_z_seq.sv
// Randomised scoreboard bench for ts_window_z_seq with a window model built
// from plain integer arithmetic and a bench-side window LUT.
module tb_ts_window_z_seq;

    localparam int ZB   = 12;
    localparam int OB   = 8;
    localparam int AB   = 6;
    localparam int ZMIN = -2048;
    localparam int ZMAX = 2047;

    typedef struct {
        int addr;
        int acc;
        int lo;
        int hi;
        int empty;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic signed [OB-1:0] mem_lo[64];
    logic signed [OB-1:0] mem_hi[64];
    bit   b2b_mode = 1'b0;
    int   last_acc = -1;
    bit   rand_rdy = 1'b0;
    bit   prev_valid = 1'b0;

    ts_window_z_seq_if #(.Z_BITS(ZB), .OFS_BITS(OB), .ADDR_BITS(AB)) bus ();

    ts_window_z_seq #(.Z_BITS(ZB), .OFS_BITS(OB), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Window LUT: data one cycle after the read strobe, noise otherwise.
    always @(posedge clk) begin
        if (bus.lut_rd) begin
            bus.lut_lo <= mem_lo[bus.lut_addr];
            bus.lut_hi <= mem_hi[bus.lut_addr];
        end else begin
            bus.lut_lo <= OB'($urandom);
            bus.lut_hi <= OB'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < ZMIN) return ZMIN;
        if (v > ZMAX) return ZMAX;
        return v;
    endfunction

    task automatic push(input int z, input int addr);
        exp_t e;
        e.addr  = addr;
        e.acc   = cyc;
        e.lo    = clampi(z + int'(mem_lo[addr]));
        e.hi    = clampi(z + int'(mem_hi[addr]));
        e.empty = (e.lo > e.hi) ? 1 : 0;
        if (b2b_mode && last_acc >= 0) check("b2b_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns one falling edge after the accept.
    task automatic send(input int z, input int addr);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_z     = ZB'(z);
        bus.in_addr  = AB'(addr);
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        push(z, addr);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: compares every presented result and LUT read against the scoreboard head.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.lut_rd) begin
                if (sb.size() == 0) check("lut_rd_unexpected", bus.lut_rd, 0);
                else begin
                    check("lut_addr", bus.lut_addr, sb[0].addr);
                    check("lut_rd_cycle", cyc - sb[0].acc, 1);
                end
            end
            if (bus.out_valid) begin
                check("in_ready_while_valid", bus.in_ready, 0);
                if (sb.size() == 0) check("out_valid_unexpected", bus.out_valid, 0);
                else begin
                    if (!prev_valid) check("out_latency", cyc - sb[0].acc, 5);
                    check("out_lo", bus.out_lo, sb[0].lo);
                    check("out_hi", bus.out_hi, sb[0].hi);
                    check("out_empty", bus.out_empty, sb[0].empty);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int z;
        int a;
        int g;
        bus.in_valid  = 1'b0;
        bus.in_z      = '0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem_lo[i] = OB'($urandom);
            mem_hi[i] = OB'($urandom);
        end
        mem_lo[3] = -8'sd20; mem_hi[3] = 8'sd30;
        mem_lo[5] = -8'sd5;  mem_hi[5] = 8'sd20;
        mem_lo[6] = -8'sd30; mem_hi[6] = 8'sd10;
        mem_lo[7] = 8'sd10;  mem_hi[7] = -8'sd10;

        repeat (3) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_lut_rd", bus.lut_rd, 0);
        check("reset_lut_addr", bus.lut_addr, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_lo", bus.out_lo, 0);
        check("reset_out_hi", bus.out_hi, 0);
        check("reset_out_empty", bus.out_empty, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: basic, both clamp directions, empty window.
        send(100, 3);   wait_idle();
        send(2040, 5);  wait_idle();
        send(-2040, 6); wait_idle();
        send(0, 7);     wait_idle();

        // Random stubs under random consumer backpressure.
        rand_rdy = 1'b1;
        repeat (20) begin
            z = int'($urandom_range(0, 4095)) - 2048;
            a = int'($urandom_range(0, 63));
            send(z, a);
        end
        wait_idle();
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;

        // Held backpressure with ignored in_valid pulses.
        bus.out_ready = 1'b0;
        send(500, 3);
        g = 0;
        while (!bus.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("bp_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = i[0];
            bus.in_z     = ZB'($urandom);
            bus.in_addr  = AB'($urandom);
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        wait_idle();

        // Back-to-back with in_valid held high.
        b2b_mode = 1'b1;
        last_acc = -1;
        repeat (5) begin
            z = int'($urandom_range(0, 4095)) - 2048;
            a = int'($urandom_range(0, 63));
            send(z, a);
        end
        b2b_mode = 1'b0;
        wait_idle();

        // Reset at cycle 3 of a transaction discards the stub.
        send(300, 3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_lut_rd", bus.lut_rd, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_lo", bus.out_lo, 0);
        check("rst_out_hi", bus.out_hi, 0);
        check("rst_out_empty", bus.out_empty, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        repeat (8) begin
            @(negedge clk);
            check("rst_no_result", bus.out_valid, 0);
        end
        send(-100, 6);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
